// File: rtl/ad_ip_jesd204_tpl_profile_seq.sv
// JESD TPL profile-switch sequencer: drains the datapath under reset, swaps the
// active profile, settles, releases and waits for link lock (up_clk domain).
module ad_ip_jesd204_tpl_profile_seq #(
    parameter int NUM_PROFILES   = 1,
    parameter int DRAIN_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int PSEL_W        = $clog2(NUM_PROFILES) + 1
) (
    input  logic              up_clk,
    input  logic              up_rst,
    input  logic              req_valid,
    input  logic [PSEL_W-1:0] req_profile,
    output logic              req_ready,
    input  logic              link_ready,
    input  logic              err_clr,
    output logic              datapath_rst,
    output logic [PSEL_W-1:0] up_profile_sel,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_range
);

    localparam int MAX_DS = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int MAX_C  = (MAX_DS > TIMEOUT_CYCLES) ? MAX_DS : TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_SWITCH, S_SETTLE, S_RELEASE, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [PSEL_W-1:0]   r_tgt, r_sel;
    logic                r_por, r_rst, r_busy, r_req_ready, r_done, r_err_to, r_err_rg;
    logic                w_hs, w_oor, w_load_tgt, w_set_rg, w_set_to;

    assign w_hs  = req_valid & r_req_ready;
    assign w_oor = (req_profile >= PSEL_W'(NUM_PROFILES));

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
        w_load_tgt = 1'b0;
        w_set_rg   = 1'b0;
        w_set_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // First cycle out of reset runs the power-on settle/release for profile 0
                if (r_por) begin
                    w_next    = S_SETTLE;
                    w_cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
                end else if (w_hs) begin
                    if (w_oor) begin
                        w_set_rg = 1'b1;
                    end else if (req_profile == r_sel) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_DRAIN;
                        w_cnt_nxt  = CNT_W'(DRAIN_CYCLES - 1);
                        w_load_tgt = 1'b1;
                    end
                end
            end
            S_DRAIN:   if (r_cnt == '0) w_next = S_SWITCH;
            S_SWITCH: begin
                w_next    = S_SETTLE;
                w_cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next    = S_RELEASE;
                    w_cnt_nxt = CNT_W'(TIMEOUT_CYCLES - 1);
                end
            end
            S_RELEASE: begin
                if (link_ready) begin
                    w_next = S_DONE;
                end else if (r_cnt == '0) begin
                    w_next   = S_IDLE;
                    w_set_to = 1'b1;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_sel       <= '0;
            r_por       <= 1'b1;
            r_rst       <= 1'b1;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b0;
            r_done      <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_rg    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_por       <= 1'b0;
            if (w_load_tgt) r_tgt <= req_profile;
            if (r_state == S_SWITCH) r_sel <= r_tgt;
            r_rst       <= (w_next == S_DRAIN) || (w_next == S_SWITCH) || (w_next == S_SETTLE);
            r_busy      <= (w_next != S_IDLE);
            r_req_ready <= (w_next == S_IDLE);
            r_done      <= (r_state == S_DONE);
            // Sticky flags: a new error in the same cycle as err_clr is kept
            if (w_set_to)     r_err_to <= 1'b1;
            else if (err_clr) r_err_to <= 1'b0;
            if (w_set_rg)     r_err_rg <= 1'b1;
            else if (err_clr) r_err_rg <= 1'b0;
        end
    end

    assign req_ready      = r_req_ready;
    assign datapath_rst   = r_rst;
    assign up_profile_sel = r_sel;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_timeout    = r_err_to;
    assign err_range      = r_err_rg;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_profile_seq.sv
// Scoreboard bench for the profile sequencer: expected done pulses (cycle and
// profile) are queued at request time and matched by a done monitor.
module tb_ad_ip_jesd204_tpl_profile_seq;

    localparam int NP = 4, DR = 16, ST = 64, TO = 1024;
    localparam int PW = 3;
    localparam int LAT_SW = DR + ST + 3;   // handshake edge -> done edge, link already up
    localparam int LAT_PO = ST + 3;        // first edge after reset release -> done edge
    localparam int RST_HI = DR + 1 + ST;
    localparam int TO_OFF = DR + 1 + ST + TO;

    typedef struct { int cyc; int sel; } exp_t;

    logic          up_clk = 1'b0, up_rst;
    logic          req_valid = 1'b0, link_ready = 1'b1, err_clr = 1'b0;
    logic [PW-1:0] req_profile = '0;
    logic          req_ready, datapath_rst, busy, done, err_timeout, err_range;
    logic [PW-1:0] up_profile_sel;

    int   cyc = 0, n_chk = 0, n_err = 0;
    exp_t sb_q[$];

    ad_ip_jesd204_tpl_profile_seq #(
        .NUM_PROFILES(NP), .DRAIN_CYCLES(DR), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
    ) dut (
        .up_clk(up_clk), .up_rst(up_rst), .req_valid(req_valid), .req_profile(req_profile),
        .req_ready(req_ready), .link_ready(link_ready), .err_clr(err_clr),
        .datapath_rst(datapath_rst), .up_profile_sel(up_profile_sel), .busy(busy),
        .done(done), .err_timeout(err_timeout), .err_range(err_range)
    );

    always #5 up_clk = ~up_clk;
    always @(posedge up_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    always @(negedge up_clk) begin
        if (!up_rst && done) begin
            if (sb_q.size() == 0) chk("done_unexp", 1, 0);
            else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cyc", cyc, e.cyc);
                chk("done_sel", int'(up_profile_sel), e.sel);
            end
        end
    end

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_dprst"}, int'(datapath_rst), 1);
        chk({tag, "_sel"},   int'(up_profile_sel), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_rdy"},   int'(req_ready), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_errs"},  int'({err_timeout, err_range}), 0);
    endtask

    task automatic release_rst();
        @(negedge up_clk);
        up_rst = 1'b0;
        sb_q.push_back('{cyc: cyc + LAT_PO, sel: 0});
    endtask

    task automatic req(input int p, input int lat, input bit exp_done);
        @(negedge up_clk);
        req_valid   = 1'b1;
        req_profile = PW'(p);
        chk("req_rdy", int'(req_ready), 1);
        if (exp_done) sb_q.push_back('{cyc: cyc + 1 + lat, sel: p});
        @(posedge up_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge up_clk);
            if (req_ready && sb_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk({tag, "_idle_tmo"}, 0, 1);
    endtask

    task automatic pulse_clr();
        @(negedge up_clk);
        err_clr = 1'b1;
        @(posedge up_clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        int rst_cnt, sel_k, done_cnt, busy_cnt, to_k;
        up_rst = 1'b1;
        repeat (3) @(negedge up_clk);
        chk_rst_vals("por");

        release_rst();
        @(negedge up_clk);
        chk("po_busy", int'(busy), 1);
        chk("po_rdy", int'(req_ready), 0);
        wait_idle("po");
        chk("po_dprst", int'(datapath_rst), 0);
        chk("po_busy_end", int'(busy), 0);

        // 0 -> 2 with link already up
        req(2, LAT_SW, 1'b1);
        rst_cnt = 0; sel_k = -1; done_cnt = 0;
        for (int k = 0; k < LAT_SW + 6; k++) begin
            @(negedge up_clk);
            if (datapath_rst) rst_cnt++;
            if (up_profile_sel == PW'(2) && sel_k < 0) sel_k = k;
            if (done) done_cnt++;
        end
        chk("sw_rst_len", rst_cnt, RST_HI);
        chk("sw_sel_edge", sel_k, DR + 1);
        chk("sw_done_cnt", done_cnt, 1);
        chk("sw_busy_end", int'(busy), 0);

        // same profile: no reset pulse, one busy cycle
        req(2, 1, 1'b1);
        rst_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge up_clk);
            if (datapath_rst) rst_cnt++;
            if (busy) busy_cnt++;
        end
        chk("same_rst", rst_cnt, 0);
        chk("same_busy", busy_cnt, 1);

        // out of range, including the NUM_PROFILES boundary
        req(5, 0, 1'b0);
        @(negedge up_clk);
        chk("rng_err", int'(err_range), 1);
        chk("rng_rdy", int'(req_ready), 1);
        chk("rng_sel", int'(up_profile_sel), 2);
        chk("rng_busy", int'(busy), 0);
        pulse_clr();
        @(negedge up_clk);
        chk("rng_clr", int'(err_range), 0);
        req(NP, 0, 1'b0);
        @(negedge up_clk);
        chk("rng_bound", int'(err_range), 1);
        @(negedge up_clk);
        err_clr     = 1'b1;
        req_valid   = 1'b1;
        req_profile = PW'(6);
        @(posedge up_clk);
        #1 begin err_clr = 1'b0; req_valid = 1'b0; end
        @(negedge up_clk);
        chk("rng_set_wins", int'(err_range), 1);
        pulse_clr();

        // link never comes up after release
        link_ready = 1'b0;
        req(1, 0, 1'b0);
        to_k = -1;
        for (int k = 0; k < TO_OFF + 20; k++) begin
            @(negedge up_clk);
            if (err_timeout && to_k < 0) begin
                to_k = k;
                chk("to_rdy", int'(req_ready), 1);
                chk("to_sel", int'(up_profile_sel), 1);
                chk("to_dprst", int'(datapath_rst), 0);
            end
        end
        chk("to_edge", to_k, TO_OFF);
        link_ready = 1'b1;
        pulse_clr();
        @(negedge up_clk);
        chk("to_clr", int'(err_timeout), 0);

        // back to 0, then reset in the middle of the 0 -> 3 settle phase
        req(0, LAT_SW, 1'b1);
        wait_idle("sw0");
        req(3, LAT_SW, 1'b1);
        repeat (DR + 25) @(negedge up_clk);
        chk("mid_sel_pre", int'(up_profile_sel), 3);
        up_rst = 1'b1;
        #1;
        sb_q.delete();
        chk_rst_vals("mid");
        @(negedge up_clk);
        release_rst();
        wait_idle("mid_po");
        chk("mid_po_sel", int'(up_profile_sel), 0);
        chk("mid_po_dprst", int'(datapath_rst), 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_profile_seq.md
# ad_ip_jesd204_tpl_profile_seq

Sequencer that switches the JESD transport-layer datapath between link profiles without corrupting samples. It sits beside the TPL register map in the up_clk domain: it accepts a software profile-switch request, holds the datapath in reset while the old profile drains, updates the active profile select, waits for the link to settle, releases reset and reports completion or timeout.

## Interface

Parameters:
- NUM_PROFILES, 1, number of supported JESD profiles (1..16)
- DRAIN_CYCLES, 16, cycles datapath reset is held before the profile changes (>=1)
- SETTLE_CYCLES, 64, cycles reset is held after the profile changes (>=1)
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for link_ready after release (>=1)
- Local PSEL_W = $clog2(NUM_PROFILES)+1

Ports:
- up_clk  in  1  processor clock; the only clock
- up_rst  in  1  asynchronous, active-high reset
- req_valid  in  1  profile-switch request
- req_profile  in  PSEL_W  requested profile index
- req_ready  out  1  request accepted when req_valid && req_ready
- link_ready  in  1  deframer/datapath reports lock on current profile
- err_clr  in  1  clears sticky error flags
- datapath_rst  out  1  active-high reset to TPL datapath
- up_profile_sel  out  PSEL_W  active profile select
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, switch completed
- err_timeout  out  1  sticky, link_ready not seen within TIMEOUT_CYCLES
- err_range  out  1  sticky, request with req_profile >= NUM_PROFILES

## Operation

- States: IDLE, DRAIN, SWITCH, SETTLE, RELEASE, DONE.
- IDLE: req_ready=1. On handshake:
  - req_profile >= NUM_PROFILES: set err_range, stay IDLE, no other effect.
  - req_profile == up_profile_sel: go DONE directly (no reset pulse).
  - otherwise latch target, go DRAIN.
- DRAIN: datapath_rst=1; counter loaded DRAIN_CYCLES-1, counts to 0, then SWITCH.
- SWITCH: one cycle; up_profile_sel <= latched target; datapath_rst=1; go SETTLE.
- SETTLE: datapath_rst=1 for exactly SETTLE_CYCLES cycles, then RELEASE.
- RELEASE: datapath_rst=0; wait link_ready. link_ready=1 -> DONE. After TIMEOUT_CYCLES cycles without link_ready: set err_timeout, go IDLE (no done pulse; profile stays switched).
- DONE: done=1 for one cycle, go IDLE.
- busy=1 in every state except IDLE; req_ready = ~busy.
- err_clr clears both sticky flags; error set and err_clr in the same cycle: set wins.
- Counter width: $clog2(max(DRAIN_CYCLES,SETTLE_CYCLES,TIMEOUT_CYCLES))+1; no wrap-around, counters saturate at 0.

## Timing

- Reset values: state IDLE, datapath_rst=1 (datapath held until first release), up_profile_sel=0, busy=0, req_ready=0 while up_rst high then 1, done=0, err_timeout=0, err_range=0.
- After up_rst deasserts, the block goes through a power-on sequence SETTLE -> RELEASE -> DONE for profile 0 before accepting requests (busy=1, req_ready=0).
- All outputs registered. Handshake at edge N -> datapath_rst=1 from N+1.
- Different-profile request, link_ready already high: datapath_rst high DRAIN_CYCLES+1+SETTLE_CYCLES cycles; up_profile_sel changes at edge N+DRAIN_CYCLES+1; RELEASE samples link_ready the cycle after rst drops; done pulse follows 1 cycle after link_ready seen.
- link_ready is sampled only in RELEASE; its value in other states is ignored.
- Same-profile request: done at N+1, busy high 1 cycle.
- Out-of-range request: err_range high from N+1; req_ready stays 1.
- up_rst mid-sequence: immediate return to reset values; pending request lost; power-on sequence restarts.

## Test plan

- Power-on, link_ready=1, DRAIN=16, SETTLE=64: datapath_rst releases 64 cycles after reset, done pulse 2 cycles later, up_profile_sel=0.
- NUM_PROFILES=4, request profile 2: rst high 81 cycles, up_profile_sel 0->2 at cycle 17, done once, busy low after.
- Request profile 2 while already on 2: done next cycle, datapath_rst never asserts.
- Request profile 5 with NUM_PROFILES=4: err_range=1, no state change; err_clr -> err_range=0.
- link_ready held 0 after release, TIMEOUT=1024: err_timeout at cycle 1024 of RELEASE, no done, req_ready returns 1.
- Assert up_rst during SETTLE of a 0->3 switch: outputs return to reset values at once, profile_sel=0, power-on sequence reruns.
